regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: ctrl_reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: a_valid  in  1  requester A (ALU writeback) write request.
REQ-004 SHALL have port: a_ready  out  1  A request accepted this cycle.
REQ-005 SHALL have port: a_reg  in  5  A destination register.
REQ-006 SHALL have port: a_data  in  32  A write data.
REQ-007 SHALL have ports b_valid, b_ready, b_reg, b_data, identical to A, for requester B (memory load).
REQ-008 SHALL have port: clear_req  in  1  single-cycle request to zero registers 1..31.
REQ-009 SHALL have port: clear_busy  out  1  high while clear sweep runs.
REQ-010 SHALL have port: ctrl_writeEnable  out  1  regfile write enable.
REQ-011 SHALL have port: ctrl_writeReg  out  5  regfile write address.
REQ-012 SHALL have port: data_writeReg  out  32  regfile write data.

Function
REQ-013 SHALL implement FSM with states RUN and CLEAR.
REQ-014 In RUN, handshake completes on valid&&ready; ready SHALL be combinational from valid, priority pointer, state, clear_req.
REQ-015 Only one valid: that requester SHALL get ready=1 regardless of pointer.
REQ-016 Both valid: requester named by pointer SHALL get ready; the other SHALL get ready=0 and hold its request.
REQ-017 Pointer SHALL reset to A and flip to the non-granted requester after every grant; no grant, no change.
REQ-018 Accepted request in cycle N SHALL appear as ctrl_writeEnable=1 with its reg/data in cycle N+1 for exactly one cycle.
REQ-019 Accepted request with reg=0 SHALL be consumed (ready=1, pointer flips) but SHALL NOT assert ctrl_writeEnable.
REQ-020 Without a write, ctrl_writeEnable SHALL be 0; ctrl_writeReg/data_writeReg SHALL hold last values.
REQ-021 clear_req=1 in RUN SHALL force a_ready=b_ready=0 that cycle and enter CLEAR next cycle.
REQ-022 In CLEAR, a 5-bit counter starting at 1 SHALL issue one write of 0x00000000 per cycle to regs 1..31 in ascending order (31 cycles); after the write to 31, state returns to RUN.
REQ-023 In CLEAR, clear_busy=1 and a_ready=b_ready=0; clear_req SHALL be ignored (no restart).
REQ-024 RUN→CLEAR transition SHALL NOT drop a write accepted in the preceding cycle; it is output before the first clear write.

Reset
REQ-025 On ctrl_reset_n=0, immediately: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, pointer=A, counter=1, clear_busy=0 (asynchronous, independent of clock).
REQ-026 Reset asserted mid-sweep SHALL abort the sweep; after deassertion state is per REQ-027/REQ-028.

Configuration
REQ-027 With REGFILE_ARB_CLEAR_EN defined: reset state SHALL be CLEAR (sweep runs automatically after every reset, clear_busy=1 from the first clock edge) and clear_req honoured per REQ-021.
REQ-028 Without REGFILE_ARB_CLEAR_EN: no CLEAR state or counter; reset state RUN; clear_req ignored; clear_busy tied 0.

Verification
REQ-029 Only A valid, a_reg=5, a_data=0xDEADBEEF -> a_ready=1; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF.
REQ-030 A and B valid continuously (regs 3/7), post-reset -> grants A,B,A,B; writeReg sequence 3,7,3,7 one per cycle.
REQ-031 A valid with a_reg=0, data 0x1 -> a_ready=1, ctrl_writeEnable stays 0; following A/B conflict grants B.
REQ-032 CLEAR_EN defined, release reset -> clear_busy=1 for 31 cycles, writes regs 1..31 with 0, requesters ready=0 throughout, then RUN.
REQ-033 CLEAR_EN, clear_req pulse then reset asserted at counter=10 -> outputs zero at once; after release the sweep restarts from reg 1.
REQ-034 CLEAR_EN undefined, clear_req=1 with A valid -> a_ready=1, clear_busy=0, no zero writes.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester round-robin arbiter for a single
// register-file write port, with an optional sweep that zeroes regs 1..31.
// Optional feature macro: REGFILE_ARB_CLEAR_EN (adds the CLEAR sweep, which
// also runs automatically after every reset). Without it the block is a
// pure arbiter: clear_req is ignored and clear_busy is tied low.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie
  logic              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic blocked_c;
  logic a_grant_c;
  logic b_grant_c;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam logic [REG_W-1:0] FIRST_REG = REG_W'(1);
  localparam logic [REG_W-1:0] LAST_REG  = REG_W'(31);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [REG_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Requesters are held off while sweeping, while the last sweep write drains,
  // and in the cycle a clear is requested
  assign blocked_c  = (state_q == ST_CLEAR) || busy_q || clear_req;
  assign clear_busy = busy_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign blocked_c        = 1'b0;
  assign clear_busy       = 1'b0;
`endif

  // Grant: a lone requester always wins; on a tie the pointer decides
  always_comb begin
    a_grant_c = !blocked_c && a_valid && (!b_valid || !ptr_q);
    b_grant_c = !blocked_c && b_valid && (!a_valid || ptr_q);
  end

  assign a_ready = a_grant_c;
  assign b_ready = b_grant_c;

  // Next-state: pointer flip, write-port payload, and sweep sequencing
  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
`ifdef REGFILE_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
`endif

    if (a_grant_c) begin
      ptr_d = 1'b1;
      if (a_reg != ZERO_REG) begin
        we_d    = 1'b1;
        wreg_d  = a_reg;
        wdata_d = a_data;
      end
    end else if (b_grant_c) begin
      ptr_d = 1'b0;
      if (b_reg != ZERO_REG) begin
        we_d    = 1'b1;
        wreg_d  = b_reg;
        wdata_d = b_data;
      end
    end

`ifdef REGFILE_ARB_CLEAR_EN
    case (state_q)
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        wreg_d  = cnt_q;
        wdata_d = DATA_W'(0);
        if (cnt_q == LAST_REG) begin
          state_d = ST_RUN;
          cnt_d   = FIRST_REG;
        end else begin
          cnt_d = cnt_q + REG_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = FIRST_REG;
      end
    endcase
`endif
  end

  // State and registered write port; reset clears the port immediately
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= ZERO_REG;
      wdata_q <= DATA_W'(0);
`ifdef REGFILE_ARB_CLEAR_EN
      state_q <= ST_CLEAR;
      cnt_q   <= FIRST_REG;
      busy_q  <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
`ifdef REGFILE_ARB_CLEAR_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Busy tracks the cycle in which each sweep write is on the port
      busy_q  <= (state_q == ST_CLEAR);
`endif
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter. Stimulus issues random and
// directed requests; a reference model predicts ready/busy and pushes every
// expected register write into a queue; a negedge monitor pops and compares.
// Honours REGFILE_ARB_CLEAR_EN the same way as the design.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        a_valid, b_valid, clear_req;
  logic        a_ready, b_ready, clear_busy;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_write_arbiter dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_reg            (a_reg),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_reg            (b_reg),
    .b_data           (b_data),
    .clear_req        (clear_req),
    .clear_busy       (clear_busy),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clock = ~clock;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam int SWEEP_WAIT = 32;
`else
  localparam int SWEEP_WAIT = 0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [36:0] exp_q[$];
  logic [4:0]  exp_reg_last;
  logic [31:0] exp_data_last;
  bit          tie_to_b;
  int          cyc;
  int          sweep_start;
  bit          mon_en = 1'b0;
  logic [36:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A sweep "starting" at cycle s means: requesters blocked s..s+32,
  // busy and zero writes visible s+2..s+32.
  function automatic void model_reset();
    exp_q.delete();
    exp_reg_last  = 5'd0;
    exp_data_last = 32'd0;
    tie_to_b      = 1'b0;
    cyc           = 0;
`ifdef REGFILE_ARB_CLEAR_EN
    sweep_start = -1;
`else
    sweep_start = -1000;
`endif
  endfunction

  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd,
                      input bit cr);
    bit sweeping, busy, blk, ea, eb;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    clear_req = cr;
    #3;
    sweeping = (cyc >= sweep_start + 1) && (cyc <= sweep_start + 31);
    busy     = (cyc >= sweep_start + 2) && (cyc <= sweep_start + 32);
    blk      = sweeping || busy;
    ea = 1'b0;
    eb = 1'b0;
`ifdef REGFILE_ARB_CLEAR_EN
    if (cr) begin
      blk = 1'b1;
      if (!sweeping) begin
        sweep_start = cyc;
        for (int r = 1; r <= 31; r++) exp_q.push_back({5'(r), 32'h0});
      end
    end
`endif
    if (!blk) begin
      ea = av && (!bv || !tie_to_b);
      eb = bv && (!av || tie_to_b);
    end
    if (ea) begin
      tie_to_b = 1'b1;
      if (ar != 5'd0) exp_q.push_back({ar, ad});
    end else if (eb) begin
      tie_to_b = 1'b0;
      if (br != 5'd0) exp_q.push_back({br, bd});
    end
    check("a_ready", 32'(a_ready), 32'(ea));
    check("b_ready", 32'(b_ready), 32'(eb));
    check("clear_busy", 32'(clear_busy), 32'(busy));
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Both requesters pushing while any post-reset sweep runs
  task automatic settle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
  endtask

  // Called just after a rising edge; checks the asynchronous clear of the port
  task automatic do_reset();
    mon_en = 1'b0;
    ctrl_reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    #1;
    check("rst_writeEnable", 32'(ctrl_writeEnable), 32'd0);
    check("rst_writeReg", 32'(ctrl_writeReg), 32'd0);
    check("rst_writeData", data_writeReg, 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Monitor: every visible write must be the next expected one; otherwise hold
  always @(negedge clock) begin
    if (mon_en) begin
      if (ctrl_writeEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_write: got reg %0d data %h expected no write (cycle %0d)",
                   ctrl_writeReg, data_writeReg, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_reg", 32'(ctrl_writeReg), 32'(mon_e[36:32]));
          check("write_data", data_writeReg, mon_e[31:0]);
          exp_reg_last  = mon_e[36:32];
          exp_data_last = mon_e[31:0];
        end
      end else begin
        check("writeEnable_low", 32'(ctrl_writeEnable), 32'd0);
        check("hold_reg", 32'(ctrl_writeReg), 32'(exp_reg_last));
        check("hold_data", data_writeReg, exp_data_last);
      end
    end
  end

  initial begin
    bit          av, bv, cr;
    logic [4:0]  ar, br;
    logic [31:0] ad, bd;

    ctrl_reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    a_reg = 5'd0; b_reg = 5'd0; a_data = 32'd0; b_data = 32'd0;
    model_reset();

    @(posedge clock);
    #1;
    do_reset();
    settle(SWEEP_WAIT);

    // Single A write
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1);

    // Continuous contention from reset: A,B,A,B
    do_reset();
    settle(SWEEP_WAIT);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, $urandom, 1'b1, 5'd7, $urandom, 1'b0);

    // reg 0 consumed without a write, then the tie goes to B
    step(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd10, 32'h5A5A5A5A, 1'b0);
    idle(1);

    // Clear request alongside an A request
    step(1'b1, 5'd12, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1);
`ifdef REGFILE_ARB_CLEAR_EN
    idle(9);
    do_reset();
    settle(SWEEP_WAIT);
`else
    idle(2);
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      av = ($urandom_range(0, 9) < 6);
      bv = ($urandom_range(0, 9) < 6);
      ar = 5'($urandom_range(0, 31));
      br = 5'($urandom_range(0, 31));
      ad = $urandom;
      bd = $urandom;
      cr = ($urandom_range(0, 49) == 0);
      step(av, ar, ad, bv, br, bd, cr);
    end

    idle(40);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
